// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, derived totals and sync windows
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_TICK_DIV  = 4;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
    localparam int VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

    // Inclusive window test used for the active-low sync pulses
    function automatic logic in_span(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// pixel_tick_div: free-running clk divider producing a one-clk pixel enable every TICK_DIV clks
module pixel_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick,
    output logic div_zero
);

    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div;

    // Count 0..TICK_DIV-1 and wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) div <= '0;
        else       div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end

    assign p_tick   = (div == DIV_LAST);
    assign div_zero = (div == '0);

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA pixel/line counters with registered, mutually aligned sync and coordinate outputs
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int TICK_DIV  = VGA_TICK_DIV
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_VIS  = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS  = coord_t'(V_DISPLAY);
    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t HS_LO  = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_HI  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_LO  = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_HI  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    coord_t h_cnt, v_cnt;
    logic   div_zero, h_last, v_last;
    logic   visible, hs_n, vs_n, first;

    pixel_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
        .clk      (clk),
        .reset    (reset),
        .p_tick   (p_tick),
        .div_zero (div_zero)
    );

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // Advance the pixel counter on each pixel tick; the line counter steps on the same edge the pixel counter wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (p_tick) begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end
    end

    // Decode visibility, sync windows and frame start from the current counters
    always_comb begin
        visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_n    = !in_span(h_cnt, HS_LO, HS_HI);
        vs_n    = !in_span(v_cnt, VS_LO, VS_HI);
        first   = (h_cnt == '0) && (v_cnt == '0) && div_zero;
    end

    // Register all outputs together so they change on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_x      <= '0;
            pix_y      <= '0;
            video_on   <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            pix_x      <= h_cnt;
            pix_y      <= v_cnt;
            video_on   <= visible;
            hsync      <= hs_n;
            vsync      <= vs_n;
            frame_tick <= first;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: table vectors, hand sequences and randomized resets against an arithmetic timing model
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       vid;
        logic       hs;
        logic       vs;
        logic       ft;
        logic       pt;
    } obs_t;

    typedef struct {
        string name;
        int    k;
        obs_t  e;
    } vec_t;

    localparam obs_t RST = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic chk_en = 1'b0;
    int   k = 0;
    int   compared = 0;
    int   mismatched = 0;

    logic       d_pt, d_vid, d_hs, d_vs, d_ft;
    logic [9:0] d_x, d_y;
    logic       s_pt, s_vid, s_hs, s_vs, s_ft;
    logic [9:0] s_x, s_y;
    obs_t       obs_d, obs_s;

    assign obs_d = {d_x, d_y, d_vid, d_hs, d_vs, d_ft, d_pt};
    assign obs_s = {s_x, s_y, s_vid, s_hs, s_vs, s_ft, s_pt};

    always #5 clk = ~clk;

    vga_sync_gen dut_d (
        .clk(clk), .reset(reset), .p_tick(d_pt), .pix_x(d_x), .pix_y(d_y),
        .video_on(d_vid), .hsync(d_hs), .vsync(d_vs), .frame_tick(d_ft)
    );

    vga_sync_gen #(
        .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .TICK_DIV(3)
    ) dut_s (
        .clk(clk), .reset(reset), .p_tick(s_pt), .pix_x(s_x), .pix_y(s_y),
        .video_on(s_vid), .hsync(s_hs), .vsync(s_vs), .frame_tick(s_ft)
    );

    // Edges since reset was last released
    always @(posedge clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    // Expected outputs after k edges: outputs show the counter state of k-1 edges
    function automatic obs_t model(int kk, int d, int hd, int hf, int hsw, int hb,
                                   int vd, int vf, int vsw, int vb);
        obs_t o;
        int ht, vt, n, p, h, v;
        if (kk == 0) return RST;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        n = kk - 1;
        p = n / d;
        h = p % ht;
        v = (p / ht) % vt;
        o.x   = 10'(h);
        o.y   = 10'(v);
        o.vid = (h < hd) && (v < vd);
        o.hs  = !(h >= hd + hf && h < hd + hf + hsw);
        o.vs  = !(v >= vd + vf && v < vd + vf + vsw);
        o.ft  = (n % (d * ht * vt)) == 0;
        o.pt  = (kk % d) == d - 1;
        return o;
    endfunction

    function automatic obs_t exp_d(int kk);
        return model(kk, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t exp_s(int kk);
        return model(kk, 3, 16, 2, 4, 3, 10, 2, 2, 3);
    endfunction

    task automatic chk(input string name, input obs_t a, input obs_t e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s k=%0d: got x=%0d y=%0d vid=%b hs=%b vs=%b ft=%b pt=%b, want x=%0d y=%0d vid=%b hs=%b vs=%b ft=%b pt=%b",
                     name, k, a.x, a.y, a.vid, a.hs, a.vs, a.ft, a.pt, e.x, e.y, e.vid, e.hs, e.vs, e.ft, e.pt);
        end
    endtask

    task automatic chk_i(input string name, input int a, input int e);
        compared++;
        if (a != e) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", name, a, e);
        end
    endtask

    function automatic vec_t mk(string n, int kk, int x, int y, bit vid, bit hs, bit ft, bit pt);
        vec_t v;
        v.name = n;
        v.k = kk;
        v.e = {10'(x), 10'(y), vid, hs, 1'b1, ft, pt};
        return v;
    endfunction

    // Continuous reference check of both instances on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cont_default", obs_d, exp_d(k));
            chk("cont_small", obs_s, exp_s(k));
        end
    end

    initial begin
        vec_t vec[12];
        int j, pt_cnt, pt_last, pt_bad, hs_low, hs_first_x, hs_last_x, vs_low, ft_n, ft1, ft2, hit;
        vec[0]  = mk("first_edge",   1,    0,   0, 1, 1, 1, 0);
        vec[1]  = mk("second_edge",  2,    0,   0, 1, 1, 0, 0);
        vec[2]  = mk("first_ptick",  3,    0,   0, 1, 1, 0, 1);
        vec[3]  = mk("pixel_one",    5,    1,   0, 1, 1, 0, 0);
        vec[4]  = mk("x639_vis",     2557, 639, 0, 1, 1, 0, 0);
        vec[5]  = mk("x640_blank",   2561, 640, 0, 0, 1, 0, 0);
        vec[6]  = mk("x655_nosync",  2621, 655, 0, 0, 1, 0, 0);
        vec[7]  = mk("x656_sync",    2625, 656, 0, 0, 0, 0, 0);
        vec[8]  = mk("x751_sync",    3005, 751, 0, 0, 0, 0, 0);
        vec[9]  = mk("x752_nosync",  3009, 752, 0, 0, 1, 0, 0);
        vec[10] = mk("x799_end",     3197, 799, 0, 0, 1, 0, 0);
        vec[11] = mk("wrap_y1",      3201, 0,   1, 1, 1, 0, 0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_default", obs_d, RST);
        chk("reset_small", obs_s, RST);
        chk_en = 1'b1;
        reset = 1'b0;

        j = 0; pt_cnt = 0; pt_last = -1; pt_bad = 0; hs_low = 0;
        hs_first_x = -1; hs_last_x = -1; vs_low = 0; ft_n = 0; ft1 = -1; ft2 = -1;
        for (int i = 1; i <= 3400; i++) begin
            @(negedge clk);
            if (j < 12 && vec[j].k == i) begin
                chk(vec[j].name, obs_d, vec[j].e);
                j++;
            end
            if (i <= 40 && d_pt) begin
                if (pt_last >= 0 && i - pt_last != 4) pt_bad++;
                pt_last = i;
                pt_cnt++;
            end
            if (i <= 3200 && !d_hs) begin
                if (hs_first_x < 0) hs_first_x = int'(d_x);
                hs_last_x = int'(d_x);
                hs_low++;
            end
            if (i <= 2550 && !s_vs) vs_low++;
            if (s_ft) begin
                ft_n++;
                if (ft1 < 0) ft1 = i;
                else if (ft2 < 0) ft2 = i;
            end
        end
        chk_i("table_consumed", j, 12);
        chk_i("ptick_count_40clk", pt_cnt, 10);
        chk_i("ptick_spacing_errors", pt_bad, 0);
        chk_i("hsync_low_clk_per_line", hs_low, 384);
        chk_i("hsync_first_x", hs_first_x, 656);
        chk_i("hsync_last_x", hs_last_x, 751);
        chk_i("vsync_low_clk_2frames", vs_low, 300);
        chk_i("frame_tick_first", ft1, 1);
        chk_i("frame_tick_period", ft2 - ft1, 1275);
        chk_i("frame_tick_count", ft_n, 3);

        hit = 0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(negedge clk);
            if (d_x == 10'd700) hit = 1;
        end
        chk_i("reach_x700", hit, 1);
        #1 reset = 1'b1;
        #1 chk("async_reset_default", obs_d, RST);
        chk("async_reset_default_small", obs_s, RST);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_i("restart_ft_default", int'(d_ft), 1);
        @(negedge clk);
        chk_i("restart_ft_default_off", int'(d_ft), 0);

        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (s_x == 10'd20 && s_y == 10'd8) hit = 1;
        end
        chk_i("reach_small_20_8", hit, 1);
        #1 reset = 1'b1;
        #1 chk("async_reset_small", obs_s, RST);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(50, 3000)) @(negedge clk);
            #($urandom_range(1, 3)) reset = 1'b1;
            #1 chk("rand_reset_default", obs_d, RST);
            chk("rand_reset_small", obs_s, RST);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
        end
        repeat (200) @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
